// File: rtl/send_dataframe.sv
// Downlink frame sender: a register-programmed word FIFO that feeds a
// valid/ready output stage, with an idle-word filler, sent/underrun statistics
// and a DISABLED/RUN/DRAIN sequencer.
module send_dataframe #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH         = 16
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [2:0]                    reg_addr,
    input  logic                          reg_wr_en,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] reg_wrdata,
    input  logic                          reg_rd_en,
    output logic [C_S_AXI_DATA_WIDTH-1:0] reg_rddata,
    output logic [C_S_AXI_DATA_WIDTH-1:0] downlinkUserData_o,
    output logic                          downlinkValid_o,
    input  logic                          downlinkReady_i
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StDisabled, StRun, StDrain} state_e;

    state_e state_q, state_d;

    logic          enable_q, enable_d;
    logic          flush_q, flush_d;
    logic          overflow_q, overflow_d;
    logic [DW-1:0] idle_q, idle_d;
    logic [DW-1:0] sent_q, sent_d;
    logic [DW-1:0] underrun_q, underrun_d;
    logic [DW-1:0] rddata_q, rddata_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    // Source of the word most recently loaded into the output register.
    logic          src_fifo_q, src_fifo_d;

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count;
    logic [8:0]    count_ext;
    logic          empty, full;

    logic          wr_ctrl, wr_status, wr_push, wr_sent, wr_under, wr_idle;
    logic          push, pop, load, accept, busy, drain_ack;
    logic [DW-1:0] head;

    // Register write decode.
    always_comb begin
        wr_ctrl   = reg_wr_en && (reg_addr == 3'd0);
        wr_status = reg_wr_en && (reg_addr == 3'd1);
        wr_push   = reg_wr_en && (reg_addr == 3'd2);
        wr_sent   = reg_wr_en && (reg_addr == 3'd3);
        wr_under  = reg_wr_en && (reg_addr == 3'd4);
        wr_idle   = reg_wr_en && (reg_addr == 3'd5);
    end

    // FIFO flags; pointers carry one extra wrap bit to tell full from empty.
    always_comb begin
        count     = wr_ptr_q - rd_ptr_q;
        count_ext = 9'(count);
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head      = mem_q[rd_ptr_q[AW-1:0]];
        // A pending flush discards any push made during the flush cycle.
        push      = wr_push && !full && !flush_q;
        pop       = load && !empty;
    end

    // FSM state register.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q <= StDisabled;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StDisabled: if (enable_q) state_d = StRun;
            StRun:      if (!enable_q) state_d = StDrain;
            StDrain: begin
                if (enable_q) begin
                    state_d = StRun;
                end else if (!out_valid_q || downlinkReady_i) begin
                    state_d = StDisabled;
                end
            end
            default:    state_d = StDisabled;
        endcase
    end

    // FSM outputs: load a new word in RUN whenever the output slot is free or consumed.
    always_comb begin
        busy      = (state_q != StDisabled);
        accept    = out_valid_q && downlinkReady_i;
        load      = (state_q == StRun) && (!out_valid_q || downlinkReady_i);
        drain_ack = (state_q == StDrain) && accept;
    end

    // Datapath and control register next-state.
    always_comb begin
        enable_d   = enable_q;
        flush_d    = 1'b0;
        overflow_d = overflow_q;
        idle_d     = idle_q;
        sent_d     = sent_q;
        underrun_d = underrun_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (wr_ctrl) begin
            enable_d = reg_wrdata[0];
            flush_d  = reg_wrdata[1];
        end
        if (wr_idle) idle_d = reg_wrdata;

        if (wr_status) begin
            overflow_d = 1'b0;
        end else if (wr_push && full && !flush_q) begin
            overflow_d = 1'b1;
        end

        if (flush_q) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (wr_sent) begin
            sent_d = '0;
        end else if (accept && src_fifo_q && (sent_q != '1)) begin
            sent_d = sent_q + 1'b1;
        end

        // Count a gap only on the transition from FIFO data to idle filler.
        if (wr_under) begin
            underrun_d = '0;
        end else if (load && empty && src_fifo_q && (underrun_q != '1)) begin
            underrun_d = underrun_q + 1'b1;
        end
    end

    // Output register next-state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        src_fifo_d  = src_fifo_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = empty ? idle_q : head;
            src_fifo_d  = !empty;
        end else if (drain_ack || (state_q == StDisabled)) begin
            out_valid_d = 1'b0;
        end
    end

    // Register read mux, captured on the read strobe.
    always_comb begin
        rddata_d = rddata_q;
        if (reg_rd_en) begin
            unique case (reg_addr)
                3'd0:    rddata_d = {30'b0, 1'b0, enable_q};
                3'd1:    rddata_d = {16'b0, count_ext[7:0], 4'b0, overflow_q, busy, full, empty};
                3'd3:    rddata_d = sent_q;
                3'd4:    rddata_d = underrun_q;
                3'd5:    rddata_d = idle_q;
                default: rddata_d = '0;
            endcase
        end
    end

    // Control, statistics and output state.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            enable_q    <= 1'b0;
            flush_q     <= 1'b0;
            overflow_q  <= 1'b0;
            idle_q      <= '0;
            sent_q      <= '0;
            underrun_q  <= '0;
            rddata_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            src_fifo_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            enable_q    <= enable_d;
            flush_q     <= flush_d;
            overflow_q  <= overflow_d;
            idle_q      <= idle_d;
            sent_q      <= sent_d;
            underrun_q  <= underrun_d;
            rddata_q    <= rddata_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            src_fifo_q  <= src_fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= reg_wrdata;
        end
    end

    assign reg_rddata         = rddata_q;
    assign downlinkUserData_o = out_data_q;
    assign downlinkValid_o    = out_valid_q;

endmodule
